// File: rtl/cpu_regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_regfile_pkg
//  Description : Shared types and helpers for the integer register file and
//                its busy scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_regfile_pkg;

   // Register address width is architectural and fixed regardless of NREGS.
   localparam int REG_AW = 5;

   typedef logic [REG_AW-1:0] reg_addr_t;

   typedef enum logic [0:0] {
      RF_INIT  = 1'b0,
      RF_READY = 1'b1
   } rf_state_e;

   // True for a register that physically exists and is writable (x0 excluded).
   function automatic logic addr_ok(input reg_addr_t a, input int unsigned nregs);
      return (a != '0) && ({27'd0, a} < nregs);
   endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_scoreboard
//  Description : Per-register busy bits for long-latency ops. Issue sets,
//                late write-back clears, flush clears everything. Flags an
//                issue to a register that is already pending.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_scoreboard
   import cpu_regfile_pkg::*;
#(
   parameter int NREGS = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_en,
   input  logic             i_iss_en,
   input  reg_addr_t        i_iss_addr,
   input  logic             i_clr_en,
   input  reg_addr_t        i_clr_addr,
   input  logic             i_flush,
   output logic [NREGS-1:0] o_busy,
   output logic             o_iss_err
);

   localparam int IW = $clog2(NREGS);

   logic [NREGS-1:0] r_busy;
   logic             r_iss_err;
   logic             w_iss_v;
   logic             w_clr_v;
   logic [IW-1:0]    w_iss_idx;
   logic [IW-1:0]    w_clr_idx;

   assign w_iss_v   = i_en && i_iss_en && addr_ok(i_iss_addr, NREGS);
   assign w_clr_v   = i_en && i_clr_en && addr_ok(i_clr_addr, NREGS);
   assign w_iss_idx = i_iss_addr[IW-1:0];
   assign w_clr_idx = i_clr_addr[IW-1:0];

   // Busy bits: flush beats everything, and an issue beats a same-cycle clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_busy    <= '0;
         r_iss_err <= 1'b0;
      end else begin
         r_iss_err <= w_iss_v && r_busy[w_iss_idx];
         if (i_flush) begin
            r_busy <= '0;
         end else begin
            if (w_clr_v) r_busy[w_clr_idx] <= 1'b0;
            if (w_iss_v) r_busy[w_iss_idx] <= 1'b1;
         end
      end
   end

   assign o_busy    = r_busy;
   assign o_iss_err = r_iss_err;

endmodule
`default_nettype wire

// File: rtl/cpu_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_regfile_sb
//  Description : Integer register file with NRP read ports, two write-back
//                ports, optional same-cycle bypass, busy scoreboard and a
//                post-reset zeroing sweep.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_regfile_sb
   import cpu_regfile_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int NRP    = 2,
   parameter int BYPASS = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NRP*REG_AW-1:0] rs_addr,
   output logic [NRP*XLEN-1:0]   rs_data,
   output logic [NRP-1:0]        rs_busy,
   input  logic                  wb0_en,
   input  logic [REG_AW-1:0]     wb0_addr,
   input  logic [XLEN-1:0]       wb0_data,
   input  logic                  wb1_en,
   input  logic [REG_AW-1:0]     wb1_addr,
   input  logic [XLEN-1:0]       wb1_data,
   input  logic                  iss_en,
   input  logic [REG_AW-1:0]     iss_addr,
   input  logic                  flush,
   output logic                  ready,
   output logic                  wb_conflict,
   output logic                  iss_err,
   output logic [XLEN-1:0]       dbg_x1,
   output logic [XLEN-1:0]       dbg_x2,
   output logic [XLEN-1:0]       dbg_x3
);

   localparam int        IW         = $clog2(NREGS);
   localparam reg_addr_t C_LAST_IDX = reg_addr_t'(NREGS - 1);

   rf_state_e        r_state;
   reg_addr_t        r_idx;
   logic             r_ready;
   logic             r_wb_conflict;
   logic [XLEN-1:0]  r_regs [NREGS];

   logic             w_run;
   logic             w_wb0_v;
   logic             w_wb1_hit;
   logic             w_same;
   logic             w_wb1_v;
   logic [NREGS-1:0] w_busy;
   logic             w_iss_err;
   reg_addr_t        w_ra;

   // Write-back qualification; wb1_hit still clears busy even when wb0 wins the data.
   assign w_run     = (r_state == RF_READY);
   assign w_wb0_v   = w_run && wb0_en && addr_ok(wb0_addr, NREGS);
   assign w_wb1_hit = w_run && wb1_en && addr_ok(wb1_addr, NREGS);
   assign w_same    = w_wb0_v && w_wb1_hit && (wb0_addr == wb1_addr);
   assign w_wb1_v   = w_wb1_hit && !w_same;

   cpu_scoreboard #(
      .NREGS (NREGS)
   ) u_scoreboard (
      .clk        (clk),
      .reset      (reset),
      .i_en       (w_run),
      .i_iss_en   (iss_en),
      .i_iss_addr (iss_addr),
      .i_clr_en   (wb1_en),
      .i_clr_addr (wb1_addr),
      .i_flush    (flush),
      .o_busy     (w_busy),
      .o_iss_err  (w_iss_err)
   );

   // Sweep FSM: zero one register per cycle starting at x1, then stay ready.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= RF_INIT;
         r_idx   <= reg_addr_t'(1);
         r_ready <= 1'b0;
      end else begin
         case (r_state)
            RF_INIT: begin
               r_idx <= r_idx + reg_addr_t'(1);
               if (r_idx == C_LAST_IDX) begin
                  r_state <= RF_READY;
                  r_ready <= 1'b1;
               end
            end
            RF_READY: r_ready <= 1'b1;
            default: begin
               r_state <= RF_INIT;
               r_ready <= 1'b0;
            end
         endcase
      end
   end

   // Array storage: the sweep owns the write port until ready; wb0 overrides wb1.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (r_state == RF_INIT) begin
            r_regs[r_idx[IW-1:0]] <= '0;
         end else begin
            if (w_wb1_v) r_regs[wb1_addr[IW-1:0]] <= wb1_data;
            if (w_wb0_v) r_regs[wb0_addr[IW-1:0]] <= wb0_data;
         end
      end
   end

   // Same-address write-back collision pulse.
   always_ff @(posedge clk) begin
      if (reset) r_wb_conflict <= 1'b0;
      else       r_wb_conflict <= w_same;
   end

   // Read ports: zero for x0, out-of-range or during sweep; optional forwarding.
   always_comb begin
      rs_data = '0;
      rs_busy = '0;
      w_ra    = '0;
      for (int p = 0; p < NRP; p++) begin
         w_ra = rs_addr[p*REG_AW +: REG_AW];
         if (w_run && addr_ok(w_ra, NREGS)) begin
            rs_data[p*XLEN +: XLEN] = r_regs[w_ra[IW-1:0]];
            rs_busy[p]              = w_busy[w_ra[IW-1:0]];
            if (BYPASS != 0) begin
               if (w_wb1_hit && (wb1_addr == w_ra)) begin
                  rs_data[p*XLEN +: XLEN] = wb1_data;
                  rs_busy[p]              = 1'b0;
               end
               if (w_wb0_v && (wb0_addr == w_ra)) begin
                  rs_data[p*XLEN +: XLEN] = wb0_data;
               end
            end
         end
      end
   end

   assign ready       = r_ready;
   assign wb_conflict = r_wb_conflict;
   assign iss_err     = w_iss_err;
   assign dbg_x1      = r_regs[1];
   assign dbg_x2      = r_regs[2];
   assign dbg_x3      = r_regs[3];

endmodule
`default_nettype wire

// File: tb/tb_cpu_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_regfile_sb
//  Description : Bench for cpu_regfile_sb, bypass and non-bypass instances
//                driven in parallel against an architectural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_regfile_sb;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NRP   = 2;
   localparam int AW    = 5;

   logic                clk = 1'b0;
   logic                reset;
   logic [NRP*AW-1:0]   rs_addr;
   logic                wb0_en, wb1_en, iss_en, flush;
   logic [AW-1:0]       wb0_addr, wb1_addr, iss_addr;
   logic [XLEN-1:0]     wb0_data, wb1_data;

   logic [NRP*XLEN-1:0] rs_data_b, rs_data_n;
   logic [NRP-1:0]      rs_busy_b, rs_busy_n;
   logic                ready_b, ready_n, conf_b, conf_n, isserr_b, isserr_n;
   logic [XLEN-1:0]     dx1_b, dx2_b, dx3_b, dx1_n, dx2_n, dx3_n;

   always #5 clk = ~clk;

   cpu_regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP), .BYPASS(1)) u_dut (
      .clk(clk), .reset(reset), .rs_addr(rs_addr), .rs_data(rs_data_b), .rs_busy(rs_busy_b),
      .wb0_en(wb0_en), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
      .wb1_en(wb1_en), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
      .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
      .ready(ready_b), .wb_conflict(conf_b), .iss_err(isserr_b),
      .dbg_x1(dx1_b), .dbg_x2(dx2_b), .dbg_x3(dx3_b));

   cpu_regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP), .BYPASS(0)) u_dut_nb (
      .clk(clk), .reset(reset), .rs_addr(rs_addr), .rs_data(rs_data_n), .rs_busy(rs_busy_n),
      .wb0_en(wb0_en), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
      .wb1_en(wb1_en), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
      .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
      .ready(ready_n), .wb_conflict(conf_n), .iss_err(isserr_n),
      .dbg_x1(dx1_n), .dbg_x2(dx2_n), .dbg_x3(dx3_n));

   // Architectural model state
   logic [XLEN-1:0] m_reg [NREGS];
   bit              m_busy [NREGS];
   bit              m_ready;
   int              m_idx;
   bit              m_conf, m_isserr;
   bit              cmp_en = 1'b0;
   int              checks = 0;
   int              errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [XLEN-1:0] exp_data(input bit byp, input logic [AW-1:0] ra);
      if (!m_ready || ra == 0) return '0;
      if (byp && wb0_en && wb0_addr != 0 && wb0_addr == ra) return wb0_data;
      if (byp && wb1_en && wb1_addr != 0 && wb1_addr == ra) return wb1_data;
      return m_reg[ra];
   endfunction

   function automatic logic exp_busy(input bit byp, input logic [AW-1:0] ra);
      if (!m_ready || ra == 0) return 1'b0;
      if (byp && wb1_en && wb1_addr == ra) return 1'b0;
      return m_busy[ra];
   endfunction

   // Advance the model by one clock edge using the inputs held during that cycle.
   task automatic model_update();
      bit w0, w1, iv;
      if (reset) begin
         m_idx = 1; m_ready = 0; m_conf = 0; m_isserr = 0;
         for (int i = 0; i < NREGS; i++) m_busy[i] = 0;
      end else if (!m_ready) begin
         m_reg[m_idx] = '0;
         if (m_idx == NREGS - 1) m_ready = 1;
         m_idx++;
         m_conf = 0; m_isserr = 0;
      end else begin
         w0 = wb0_en && wb0_addr != 0;
         w1 = wb1_en && wb1_addr != 0;
         iv = iss_en && iss_addr != 0;
         m_conf   = w0 && w1 && (wb0_addr == wb1_addr);
         m_isserr = iv && m_busy[iss_addr];
         if (w1) m_reg[wb1_addr] = wb1_data;
         if (w0) m_reg[wb0_addr] = wb0_data;
         if (flush) begin
            for (int i = 0; i < NREGS; i++) m_busy[i] = 0;
         end else begin
            if (w1) m_busy[wb1_addr] = 0;
            if (iv) m_busy[iss_addr] = 1;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle();
      wb0_en = 0; wb0_addr = '0; wb0_data = '0;
      wb1_en = 0; wb1_addr = '0; wb1_data = '0;
      iss_en = 0; iss_addr = '0; flush = 0;
   endtask

   // Compare every output of both instances against the model each cycle.
   always @(negedge clk) begin
      if (cmp_en) begin
         for (int p = 0; p < NRP; p++) begin
            logic [AW-1:0] ra;
            ra = rs_addr[p*AW +: AW];
            chk("rs_data_byp", {32'd0, rs_data_b[p*XLEN +: XLEN]}, {32'd0, exp_data(1, ra)});
            chk("rs_data_nobyp", {32'd0, rs_data_n[p*XLEN +: XLEN]}, {32'd0, exp_data(0, ra)});
            chk("rs_busy_byp", {63'd0, rs_busy_b[p]}, {63'd0, exp_busy(1, ra)});
            chk("rs_busy_nobyp", {63'd0, rs_busy_n[p]}, {63'd0, exp_busy(0, ra)});
         end
         chk("ready", {62'd0, ready_b, ready_n}, {62'd0, m_ready, m_ready});
         chk("wb_conflict", {62'd0, conf_b, conf_n}, {62'd0, m_conf, m_conf});
         chk("iss_err", {62'd0, isserr_b, isserr_n}, {62'd0, m_isserr, m_isserr});
         if (m_ready) begin
            chk("dbg_x1", {dx1_b, dx1_n}, {m_reg[1], m_reg[1]});
            chk("dbg_x2", {dx2_b, dx2_n}, {m_reg[2], m_reg[2]});
            chk("dbg_x3", {dx3_b, dx3_n}, {m_reg[3], m_reg[3]});
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      idle();
      rs_addr = '0;
      reset   = 1;
      tick();
      cmp_en  = 1;
      reset   = 0;

      // 1: sweep length after reset
      n = 0;
      while (!ready_b && n < 100) begin tick(); n++; end
      chk("t1_sweep_cycles", 64'(n), 64'd31);
      chk("t1_dbg_x1_zero", {32'd0, dx1_b}, 64'd0);

      // 2: bypass of wb0 to same-cycle read
      rs_addr = {5'd0, 5'd5};
      wb0_en = 1; wb0_addr = 5'd5; wb0_data = 32'hDEADBEEF;
      @(negedge clk);
      chk("t2_byp_same_cycle", {32'd0, rs_data_b[31:0]}, 64'hDEADBEEF);
      chk("t2_nobyp_old", {32'd0, rs_data_n[31:0]}, 64'd0);
      tick(); idle();
      @(negedge clk);
      chk("t2_nobyp_next", {32'd0, rs_data_n[31:0]}, 64'hDEADBEEF);
      tick();

      // 3: write-back collision
      wb0_en = 1; wb0_addr = 5'd7; wb0_data = 32'h11;
      wb1_en = 1; wb1_addr = 5'd7; wb1_data = 32'h22;
      tick(); idle();
      rs_addr = {5'd0, 5'd7};
      @(negedge clk);
      chk("t3_x7", {rs_data_b[31:0], rs_data_n[31:0]}, {32'h11, 32'h11});
      chk("t3_conflict", {63'd0, conf_b}, 64'd1);
      tick();
      @(negedge clk);
      chk("t3_conflict_pulse", {63'd0, conf_b}, 64'd0);
      tick();

      // 4: scoreboard set/clear
      iss_en = 1; iss_addr = 5'd9;
      tick(); idle();
      rs_addr = {5'd0, 5'd9};
      @(negedge clk);
      chk("t4_busy_set", {63'd0, rs_busy_b[0]}, 64'd1);
      tick();
      wb1_en = 1; wb1_addr = 5'd9; wb1_data = 32'h33;
      @(negedge clk);
      chk("t4_busy_masked", {62'd0, rs_busy_b[0], rs_busy_n[0]}, 64'b01);
      chk("t4_byp_data", {32'd0, rs_data_b[31:0]}, 64'h33);
      tick(); idle();
      iss_en = 1; iss_addr = 5'd9;
      wb1_en = 1; wb1_addr = 5'd9; wb1_data = 32'h44;
      tick(); idle();
      @(negedge clk);
      chk("t4_set_wins", {62'd0, rs_busy_b[0], rs_busy_n[0]}, 64'b11);
      tick();

      // 5: iss_err, flush, x0
      iss_en = 1; iss_addr = 5'd3;
      tick();
      @(negedge clk);
      chk("t5_no_err_first", {63'd0, isserr_b}, 64'd0);
      tick(); idle();
      @(negedge clk);
      chk("t5_err_second", {63'd0, isserr_b}, 64'd1);
      tick();
      flush = 1; rs_addr = {5'd9, 5'd3};
      tick(); idle();
      @(negedge clk);
      chk("t5_flush", {62'd0, rs_busy_b}, 64'd0);
      tick();
      wb0_en = 1; wb0_addr = 5'd0; wb0_data = 32'hFF; rs_addr = {5'd0, 5'd0};
      @(negedge clk);
      chk("t5_x0_byp", {32'd0, rs_data_b[31:0]}, 64'd0);
      tick(); idle();
      iss_en = 1; iss_addr = 5'd4; flush = 1;
      tick(); idle();
      rs_addr = {5'd0, 5'd4};
      @(negedge clk);
      chk("t5_flush_beats_iss", {62'd0, rs_busy_b[0], rs_busy_n[0]}, 64'd0);
      tick();

      // Randomized traffic
      for (int c = 0; c < 2000; c++) begin
         rs_addr  = {5'($urandom_range(0, 11)), 5'($urandom_range(0, 11))};
         if ($urandom_range(0, 7) == 0) rs_addr[4:0] = 5'($urandom_range(0, 31));
         wb0_en   = 1'($urandom_range(0, 1));
         wb0_addr = 5'($urandom_range(0, 11));
         wb0_data = $urandom;
         wb1_en   = 1'($urandom_range(0, 1));
         wb1_addr = 5'($urandom_range(0, 11));
         wb1_data = $urandom;
         flush    = ($urandom_range(0, 15) == 0);
         iss_en   = flush ? 1'b0 : 1'($urandom_range(0, 1));
         iss_addr = 5'($urandom_range(0, 11));
         tick();
      end
      idle();
      tick();

      // 6: reset mid-sweep restarts the sweep; writes during sweep ignored
      wb0_en = 1; wb0_addr = 5'd1; wb0_data = 32'h55;
      tick(); idle();
      reset = 1; tick(); reset = 0;
      repeat (9) tick();
      reset = 1; tick(); reset = 0;
      wb0_en = 1; wb0_addr = 5'd2; wb0_data = 32'h77;
      wb1_en = 1; wb1_addr = 5'd3; wb1_data = 32'h88;
      iss_en = 1; iss_addr = 5'd2;
      n = 0;
      while (!ready_b && n < 100) begin tick(); n++; end
      idle();
      chk("t6_resweep_cycles", 64'(n), 64'd31);
      @(negedge clk);
      chk("t6_dbg_zero", {dx1_b, dx2_b}, 64'd0);
      chk("t6_dbg_x3_zero", {32'd0, dx3_n}, 64'd0);
      tick();

      cmp_en = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
